// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the iterative multiply/divide unit
// Contents: op encoding (funct3), FSM state encoding, default XLEN, two's-complement negate.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Wide enough for a 2*64-bit product; callers size-cast in and out.
    function automatic logic [127:0] md_neg(input logic [127:0] v);
        return ~v + 128'd1;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - product/remainder register, shift-add / restoring-divide step, sign fix
// Ports: clk_i, rst_i; start_i latches op and operand magnitudes; step_i advances one iteration;
//        finish_i registers the sign-corrected final step into result_o; early_o flags operands
//        with a trivially known result (only when MULDIV_EARLY_OUT_EN is defined), loaded on start_i.
module muldiv_datapath import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            step_i,
    input  logic            finish_i,
    output logic            early_o,
    output logic [XLEN-1:0] result_o
);

    localparam int W2 = 2 * XLEN;

    md_op_e          op_q;
    logic [W2-1:0]   acc_q;
    logic [XLEN-1:0] b_q;
    logic            res_neg_q;
    logic            rem_neg_q;

    logic            is_div, a_neg, b_neg, b_zero;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        is_div = op_i inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        a_neg  = (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && rs1_i[XLEN-1];
        b_neg  = (op_i inside {MD_MULH, MD_DIV, MD_REM}) && rs2_i[XLEN-1];
        b_zero = (rs2_i == '0);
        a_mag  = a_neg ? XLEN'(md_neg(128'(rs1_i))) : rs1_i;
        b_mag  = b_neg ? XLEN'(md_neg(128'(rs2_i))) : rs2_i;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            div_ovf, mul_zero;
    logic [XLEN-1:0] early_res;
    always_comb begin
        div_ovf   = (op_i inside {MD_DIV, MD_REM}) && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        mul_zero  = !is_div && ((rs1_i == '0) || b_zero);
        early_o   = (is_div && b_zero) || div_ovf || mul_zero;
        early_res = '0;
        if (is_div && b_zero)
            early_res = op_i[1] ? rs1_i : '1;
        else if (div_ovf)
            early_res = op_i[1] ? '0 : rs1_i;
    end
`else
    logic [XLEN-1:0] early_res;
    assign early_o   = 1'b0;
    assign early_res = '0;
`endif

    // One iteration of either algorithm, chosen by the latched op.
    logic [XLEN:0]   mul_sum, rem_sh;
    logic            div_ok;
    logic [W2-1:0]   acc_next, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, final_res;

    always_comb begin
        mul_sum = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = acc_q[W2-1:XLEN-1];
        div_ok  = (rem_sh >= {1'b0, b_q});
        if (op_q[2])
            acc_next = {(div_ok ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ok};
        else
            acc_next = {mul_sum, acc_q[XLEN-1:1]};

        prod_fix = res_neg_q ? W2'(md_neg(128'(acc_next))) : acc_next;
        quo_fix  = res_neg_q ? XLEN'(md_neg(128'(acc_next[XLEN-1:0]))) : acc_next[XLEN-1:0];
        rem_fix  = rem_neg_q ? XLEN'(md_neg(128'(acc_next[W2-1:XLEN]))) : acc_next[W2-1:XLEN];

        case (op_q)
            MD_MUL:                       final_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[W2-1:XLEN];
            MD_DIV, MD_DIVU:              final_res = quo_fix;
            default:                      final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= MD_MUL;
            acc_q     <= '0;
            b_q       <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_o  <= '0;
        end else if (start_i) begin
            op_q      <= op_i;
            acc_q     <= {{XLEN{1'b0}}, a_mag};
            b_q       <= b_mag;
            // Divide by zero keeps the all-ones quotient unsigned; the remainder
            // naturally ends up as |rs1| and only needs the dividend sign.
            res_neg_q <= (a_neg ^ b_neg) && !(is_div && b_zero);
            rem_neg_q <= a_neg;
            if (early_o)
                result_o <= early_res;
        end else if (step_i) begin
            acc_q <= acc_next;
            if (finish_i)
                result_o <= final_res;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit (FSM, counter, handshake)
// Ports: clk_i, rst_i (sync, active-high); valid_i/ready_o request handshake with op_i, rs1_i,
//        rs2_i, rd_addr_i; flush_i kills in-flight work; busy_o stalls the pipeline;
//        valid_o pulses for one cycle with result_o/rd_addr_o.
// Build option: MULDIV_EARLY_OUT_EN lets trivial cases skip the iterative phase.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rd_q;
    logic             accept, early, last_step, finish;

    assign ready_o   = (state_q == ST_IDLE);
    assign busy_o    = (state_q != ST_IDLE) && !(state_q == ST_DONE);
    assign valid_o   = (state_q == ST_DONE) && !flush_i;
    assign accept    = valid_i && ready_o && !flush_i;
    assign last_step = (cnt_q == CNT_W'(1));
    assign finish    = (state_q == ST_CALC) && last_step && !flush_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = early ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush_i)        state_d = ST_IDLE;
                else if (last_step) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            rd_addr_o <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= CNT_W'(XLEN);
                rd_q  <= rd_addr_i;
                if (early)
                    rd_addr_o <= rd_addr_i;
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (finish)
                    rd_addr_o <= rd_q;
            end
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (accept),
        .op_i     (md_op_e'(op_i)),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .step_i   (state_q == ST_CALC),
        .finish_i (finish),
        .early_o  (early),
        .result_o (result_o)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk, rst_i, valid_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_addr_i;
    logic        ready_o, busy_o, valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          t;
    } exp_t;
    exp_t sb_q[$];

    int tests = 0;
    int fails = 0;
    int last_acc = 0, last_lat = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!op[2] && (a == 0 || b == 0)) return 1;
`endif
        return 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every valid_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid_o=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("result", 64'(result_o), 64'(e.res));
                chk("rd_addr", 64'(rd_addr_o), 64'(e.rd));
                chk("latency_cycle", 64'(cyc), 64'(e.t));
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input bit junk, input bit b2b,
                         output int acc);
        int n;
        int lat;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            valid_i = junk;
            if (junk) begin
                op_i      = 3'($urandom);
                rs1_i     = $urandom;
                rs2_i     = $urandom;
                rd_addr_i = 5'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ready_o=0 for %0d cycles expected ready_o=1", n);
        end
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
        @(posedge clk);
        #1;
        acc = cyc;
        lat = latency(op, a, b);
        if (b2b) chk("b2b_accept_gap", 64'(acc - last_acc), 64'(last_lat + 2));
        last_acc = acc;
        last_lat = lat;
        valid_i = junk;
        if (push) begin
            e.res = ref_model(op, a, b);
            e.rd  = rd;
            e.t   = acc + lat;
            sb_q.push_back(e);
            last_exp = e.res;
            last_rd  = rd;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    initial begin
        int acc, bad, n;
        vec_t dirs[$];
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_result", 64'(result_o), 64'd0);
        chk("reset_rd", 64'(rd_addr_o), 64'd0);
        rst_i = 1'b0;

        // MUL 7 x -3 with busy/ready timeline
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 1'b0, 1'b0, acc);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (busy_o !== 1'b1 || ready_o !== 1'b0) bad++;
        end
        chk("calc_busy_ready_errors", 64'(bad), 64'd0);
        @(negedge clk);
        chk("done_busy", 64'(busy_o), 64'd0);
        chk("done_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        chk("after_done_ready", 64'(ready_o), 64'd1);

        // Directed corners, back-to-back with junk requests held during busy
        dirs = '{
            '{3'd1, 32'h8000_0000, 32'h8000_0000}, '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd2, 32'hFFFF_FFFF, 32'd2},         '{3'd4, 32'hFFFF_FFF9, 32'd2},
            '{3'd6, 32'hFFFF_FFF9, 32'd2},         '{3'd5, 32'h1234_5678, 32'd0},
            '{3'd6, 32'h1234_5678, 32'd0},         '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF}, '{3'd0, 32'd0, 32'd9},
            '{3'd5, 32'd100, 32'd7},               '{3'd7, 32'd100, 32'd7}
        };
        foreach (dirs[i])
            issue(dirs[i].op, dirs[i].a, dirs[i].b, 5'(i + 1), 1'b1, 1'b1, i > 0, acc);

        // Flush at edge 10 of a DIV
        issue(3'd4, 32'd1000, 32'd3, 5'd20, 1'b0, 1'b0, 1'b0, acc);
        wait_cyc(acc + 9);
        flush_i = 1'b1;
        wait_cyc(acc + 10);
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(ready_o), 64'd1);
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_result_kept", 64'(result_o), 64'(last_exp));
        chk("flush_rd_kept", 64'(rd_addr_o), 64'(last_rd));
        issue(3'd0, 32'd3, 32'd4, 5'd9, 1'b1, 1'b0, 1'b0, acc);

        // Flush in the DONE cycle suppresses valid_o
        issue(3'd5, 32'd77, 32'd5, 5'd11, 1'b0, 1'b0, 1'b0, acc);
        wait_cyc(acc + last_lat);
        flush_i = 1'b1;
        @(negedge clk);
        chk("done_flush_valid", 64'(valid_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;

        // Flush coincident with valid_i in IDLE: not accepted
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd5;
        @(posedge clk);
        #1;
        chk("flush_idle_not_accepted", 64'(ready_o), 64'd1);
        valid_i = 1'b0; flush_i = 1'b0;

        // Reset mid-CALC
        issue(3'd0, 32'd5, 32'd6, 5'd17, 1'b0, 1'b0, 1'b0, acc);
        wait_cyc(acc + 5);
        rst_i = 1'b1;
        wait_cyc(acc + 6);
        rst_i = 1'b0;
        chk("midrst_ready", 64'(ready_o), 64'd1);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_result", 64'(result_o), 64'd0);
        chk("midrst_rd", 64'(rd_addr_o), 64'd0);

        // Randomised back-to-back traffic
        for (int i = 0; i < 1000; i++)
            issue(3'($urandom), pick(), pick(), 5'($urandom), 1'b1, i[0], i > 0, acc);
        valid_i = 1'b0;

        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d outstanding results expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
